// File: rtl/prio_arb_pkg.sv
// Shared constants for the priority / round-robin arbiter:
// arbitration mode encodings and the two-state grant FSM encoding.
package prio_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection.
// Fixed mode: highest set index of vec.
// Round-robin mode: first set bit after start, wrapping modulo N. The vector
// is doubled so the wrap becomes a plain upward scan over the window
// (start, start+N]; the lowest hit in that window is the winner.
module prio_pick
    import prio_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [IDXW-1:0] start,
    input  logic            mode,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] win;
    logic [2*N-1:0] cand;

    assign dbl = {vec, vec};

    // Window mask selecting positions start+1 .. start+N of the doubled vector
    for (genvar gi = 0; gi < 2 * N; gi++) begin : g_win
        assign win[gi] = (gi > int'(start)) && (gi <= int'(start) + N);
    end

    assign cand = dbl & win;

    // Priority scan; later assignments in each loop override earlier ones
    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (mode == MODE_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    found = 1'b1;
                    idx   = IDXW'(i);
                end
            end
        end else begin
            for (int i = 2 * N - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    idx   = (i >= N) ? IDXW'(i - N) : IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Registered N-requester arbiter with fixed-priority and round-robin modes.
// A grant is held until the winner acks (release, optional back-to-back
// regrant) or drops its request (withdraw). All outputs come from flops.
module prio_rr_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot
);

    logic [0:0]      state_reg;
    logic [0:0]      state_next;
    logic [IDXW-1:0] rr_ptr_reg;
    logic [IDXW-1:0] rr_ptr_next;
    logic            valid_next;
    logic [IDXW-1:0] idx_next;
    logic [N-1:0]    onehot_next;

    logic            release_ack;
    logic [IDXW-1:0] pick_start;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;

    // On an ack edge the pointer moves to the releasing index in the same
    // cycle, so the regrant must already scan from there.
    assign release_ack = (state_reg == GRANT) && ack;
    assign pick_start  = release_ack ? gnt_idx : rr_ptr_reg;

    prio_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .vec   (req),
        .start (pick_start),
        .mode  (mode),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic: arbitrate from IDLE, release / withdraw / hold in GRANT
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        valid_next  = gnt_valid;
        idx_next    = gnt_idx;
        case (state_reg)
            IDLE: begin
                if (en && pick_found) begin
                    state_next = GRANT;
                    valid_next = 1'b1;
                    idx_next   = pick_idx;
                end
            end
            default: begin
                if (ack) begin
                    rr_ptr_next = gnt_idx;
                    if (en && pick_found) begin
                        idx_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end
                end else if (!req[gnt_idx]) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
        endcase
    end

    // One-hot decode of the next grant; all zero when no grant follows
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign onehot_next[gi] = valid_next && (idx_next == IDXW'(gi));
    end

    // State, pointer and output registers; reset drops any grant at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= IDXW'(N - 1);
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            gnt_valid  <= valid_next;
            gnt_idx    <= idx_next;
            gnt_onehot <= onehot_next;
        end
    end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Bench for prio_rr_arbiter: an N=8 and an N=5 instance share control
// inputs. A driver applies inputs at the falling edge, steps a behavioural
// model and queues the expected outputs; a monitor pops and compares after
// each rising edge. Directed sequences also check fixed known values.
module tb_prio_rr_arbiter;

    typedef struct {
        bit v;
        int idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;

    logic       gv8, gv5;
    logic [2:0] gi8, gi5;
    logic [7:0] go8;
    logic [4:0] go5;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    bit   m_valid[2];
    int   m_idx[2];
    int   m_ptr[2];
    int   n_of[2] = '{8, 5};

    always #5 clk = ~clk;

    prio_rr_arbiter #(.N(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req8), .ack(ack),
        .gnt_valid(gv8), .gnt_idx(gi8), .gnt_onehot(go8)
    );

    prio_rr_arbiter #(.N(5)) u5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req5), .ack(ack),
        .gnt_valid(gv5), .gnt_idx(gi5), .gnt_onehot(go5)
    );

    // Winner by the plain rules: highest index, or first hit after ptr mod n
    function automatic int ref_pick(logic [7:0] r, int n, bit m, int ptr);
        if (m == 1'b0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                int j;
                j = (ptr + k) % n;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_step(int d, bit r, bit e, bit m, logic [7:0] q, bit a);
        exp_t x;
        if (r) begin
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_ptr[d]   = n_of[d] - 1;
        end else if (!m_valid[d]) begin
            if (e && q != 0) begin
                m_valid[d] = 1'b1;
                m_idx[d]   = ref_pick(q, n_of[d], m, m_ptr[d]);
            end
        end else if (a) begin
            m_ptr[d] = m_idx[d];
            if (e && q != 0) m_idx[d] = ref_pick(q, n_of[d], m, m_ptr[d]);
            else m_valid[d] = 1'b0;
        end else if (!q[m_idx[d]]) begin
            m_valid[d] = 1'b0;
        end
        x.v   = m_valid[d];
        x.idx = m_idx[d];
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic get_out(int d, output bit v, output int idx, output logic [7:0] oh);
        if (d == 0) begin
            v = gv8; idx = int'(gi8); oh = go8;
        end else begin
            v = gv5; idx = int'(gi5); oh = {3'b000, go5};
        end
    endtask

    // Apply one cycle of inputs; a rising rst is checked before the next edge
    task automatic drive(bit r, bit e, bit m, logic [7:0] q8, logic [4:0] q5, bit a);
        bit rising;
        @(negedge clk);
        rising = r && !rst;
        rst = r; en = e; mode = m; req8 = q8; req5 = q5; ack = a;
        if (rising) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                bit v; int idx; logic [7:0] oh;
                get_out(d, v, idx, oh);
                tests++;
                if (v !== 1'b0 || idx != 0 || oh !== 8'h00) begin
                    fails++;
                    $display("FAIL async_reset dut%0d: got v=%0b idx=%0d oh=%h, want 0 0 00", d, v, idx, oh);
                end
            end
        end
        model_step(0, r, e, m, q8, a);
        model_step(1, r, e, m, {3'b000, q5}, a);
        mon_on = 1'b1;
    endtask

    // Fixed-value check after the coming rising edge
    task automatic chk(string name, int d, bit ev, int eidx);
        bit v; int idx; logic [7:0] oh;
        @(posedge clk);
        #2;
        get_out(d, v, idx, oh);
        tests++;
        if (v !== ev || (ev && idx != eidx)) begin
            fails++;
            $display("FAIL %s dut%0d: got v=%0b idx=%0d, want v=%0b idx=%0d", name, d, v, idx, ev, eidx);
        end
    endtask

    task automatic mon_check(int d);
        exp_t x;
        bit v; int idx; logic [7:0] oh; logic [7:0] want_oh;
        get_out(d, v, idx, oh);
        tests++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL scoreboard_empty dut%0d: got v=%0b idx=%0d, want a queued entry", d, v, idx);
            return;
        end
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        want_oh = x.v ? (8'd1 << x.idx) : 8'd0;
        if (v !== x.v || (x.v && idx != x.idx) || oh !== want_oh) begin
            fails++;
            $display("FAIL grant dut%0d t=%0t: got v=%0b idx=%0d oh=%h, want v=%0b idx=%0d oh=%h",
                     d, $time, v, idx, oh, x.v, x.idx, want_oh);
        end else if (x.v) begin
            $display("[TB] dut%0d t=%0t grant idx=%0d", d, $time, idx);
        end
    endtask

    // Monitor: compare both instances shortly after every rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                mon_check(0);
                mon_check(1);
            end
        end
    end

    initial begin
        bit r, e, m, a;
        logic [7:0] q8;
        logic [4:0] q5;

        // Reset with everything requesting, then first grant in fixed mode
        drive(1, 1, 0, 8'hFF, 5'h1F, 0);
        drive(0, 1, 0, 8'hFF, 5'h1F, 0);
        chk("reset_first_grant", 0, 1, 7);

        // Fixed priority with lock, then back-to-back regrant on ack
        drive(1, 1, 0, 8'h00, 5'h00, 0);
        drive(0, 1, 0, 8'b01100110, 5'h00, 0);
        chk("fixed_pick", 0, 1, 6);
        drive(0, 1, 0, 8'b11100110, 5'h00, 0);
        chk("fixed_lock", 0, 1, 6);
        drive(0, 1, 0, 8'b11100110, 5'h00, 1);
        chk("fixed_regrant", 0, 1, 7);

        // Round-robin rotation with ack on every grant
        drive(1, 1, 1, 8'h00, 5'h00, 0);
        drive(0, 1, 1, 8'b00110011, 5'h00, 0);
        chk("rr_seq0", 0, 1, 0);
        drive(0, 1, 1, 8'b00110011, 5'h00, 1); chk("rr_seq1", 0, 1, 1);
        drive(0, 1, 1, 8'b00110011, 5'h00, 1); chk("rr_seq2", 0, 1, 4);
        drive(0, 1, 1, 8'b00110011, 5'h00, 1); chk("rr_seq3", 0, 1, 5);
        drive(0, 1, 1, 8'b00110011, 5'h00, 1); chk("rr_seq4", 0, 1, 0);
        drive(0, 1, 1, 8'b00110011, 5'h00, 1); chk("rr_seq5", 0, 1, 1);

        // Withdraw: one idle cycle, then the remaining requester wins
        drive(1, 1, 0, 8'h00, 5'h00, 0);
        drive(0, 1, 0, 8'b00001001, 5'h00, 0); chk("wd_grant", 0, 1, 3);
        drive(0, 1, 0, 8'b00000001, 5'h00, 0); chk("wd_gap", 0, 0, 0);
        drive(0, 1, 0, 8'b00000001, 5'h00, 0); chk("wd_next", 0, 1, 0);

        // Enable gating
        drive(1, 0, 0, 8'h00, 5'h00, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 8'b00000011, 5'h00, 0);
            chk("en_off", 0, 0, 0);
        end
        drive(0, 1, 0, 8'b00000011, 5'h00, 0); chk("en_on", 0, 1, 1);
        drive(0, 0, 0, 8'b00000011, 5'h00, 1); chk("en_no_regrant", 0, 0, 0);

        // Non-power-of-two wrap on the N=5 instance, then reset mid-grant
        drive(1, 1, 1, 8'h00, 5'h00, 0);
        drive(0, 1, 1, 8'h00, 5'b10001, 0); chk("n5_seq0", 1, 1, 0);
        drive(0, 1, 1, 8'h00, 5'b10001, 1); chk("n5_seq1", 1, 1, 4);
        drive(0, 1, 1, 8'h00, 5'b10001, 1); chk("n5_seq2", 1, 1, 0);
        drive(0, 1, 1, 8'h00, 5'b10001, 1); chk("n5_seq3", 1, 1, 4);
        drive(1, 1, 1, 8'h00, 5'b10001, 0);

        // Randomized traffic against the model
        m = 1'b0;
        for (int i = 0; i < 700; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) m = ~m;
            q8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            q5 = ($urandom_range(0, 5) == 0) ? 5'h00 : 5'($urandom);
            a  = ($urandom_range(0, 2) == 0);
            drive(r, e, m, q8, q5, a);
        end

        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_rr_arbiter.md
Name: prio_rr_arbiter

Overview:
Parametrised N-requester arbiter that extends the 8-to-3 priority encoder into a registered, handshaked grant engine. It selects in either fixed-priority mode (highest index wins) or round-robin mode, and locks the grant until the winner acknowledges or withdraws. It sits between request sources and a single shared resource, and outputs both a binary index and a one-hot grant.

Parameters:
N, 8, number of requesters; legal range 2..64, non-power-of-two allowed.
IDXW, $clog2(N), width of the grant index; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  arbitration enable; gates new grants only
mode  input  1  0 = fixed priority (MODE_FIXED), 1 = round-robin (MODE_RR)
req  input  N  request vector, bit i = requester i
ack  input  1  winner has finished; releases the current grant
gnt_valid  output  1  a grant is active
gnt_idx  output  IDXW  index of the granted requester
gnt_onehot  output  N  one-hot grant; all zero when gnt_valid=0

Behaviour:
- Reset (async, immediate): state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, rr_ptr=N-1. Reset mid-grant drops the grant without waiting for a clock edge.
- All outputs are registered. There is no combinational path from req, ack or en to any output.
- States:
  - IDLE: at an edge with en=1 and |req=1, pick a winner, load the outputs and go to GRANT. Otherwise stay in IDLE.
  - GRANT: outputs hold stable until release.
    - ack=1 releases the grant (ack has priority over withdraw).
    - ack=0 with req[gnt_idx]=0 is a withdraw: gnt_valid=0 next cycle, go to IDLE, rr_ptr unchanged.
- On release by ack:
  - rr_ptr <= gnt_idx.
  - If en=1 and |req=1 at that same edge, re-arbitrate immediately and regrant back-to-back (gnt_valid stays 1, state stays GRANT). Arbitration uses the current req, including the releasing requester.
  - Otherwise gnt_valid=0 and go to IDLE.
- Winner selection:
  - Fixed mode: highest set index in req.
  - RR mode: first set bit scanning rr_ptr+1, rr_ptr+2, … modulo N (wrap from N-1 to 0).
  - mode and en are sampled only at arbitration edges. Changing them during GRANT has no effect on the held grant.
  - rr_ptr updates on every ack, in both modes, so switching to RR resumes fairly.
- Latency: request to grant is 1 cycle from IDLE; ack to next grant is 1 cycle.
- en=0 during GRANT: the current grant completes normally, but no regrant follows.
- req=0 with en=1 in IDLE: remain in IDLE.
- ack while gnt_valid=0: ignored.
- Invariant: gnt_onehot == (1 << gnt_idx) when gnt_valid=1, else 0.
- Modulo wrap must be correct for non-power-of-two N (e.g. N=5: pointer 4 wraps to 0).

Decomposition:
- Package prio_arb_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - State encoding IDLE=1'b0, GRANT=1'b1.
- Sub-module prio_pick, purely combinational:
  - Inputs: N-bit vector, start index, mode.
  - Outputs: found flag and IDXW-bit index.
  - Implemented as a double-width masked priority scan.
- prio_rr_arbiter instantiates one prio_pick and owns the FSM, rr_ptr and output registers.

Test Plan (N=8 unless stated):
- Reset: assert rst with req=8'hFF, en=1 → gnt_valid=0, gnt_idx=0, gnt_onehot=0 immediately. After release, first edge grants idx 7 in fixed mode.
- Fixed priority with lock: mode=0, req=8'b01100110 → 1 cycle later gnt_idx=6, gnt_onehot=8'b01000000. Change req to 8'b11100110 with ack=0 → grant stays 6. Pulse ack → next cycle gnt_idx=7, with no gnt_valid gap.
- Round-robin rotation: mode=1 from reset, req=8'b00110011 held, ack pulsed every grant → grant sequence 0,1,4,5,0,1 with gnt_valid continuously 1 after the first grant.
- Withdraw: mode=0, req=8'b00001001 → grant 3. Drop req to 8'b00000001 with ack=0 → gnt_valid=0 for exactly one cycle, then gnt_idx=0.
- Enable gating: en=0, req=8'b00000011 for 5 cycles → gnt_valid stays 0. Set en=1 → next cycle gnt_idx=1. Set en=0 and then ack → gnt_valid=0 with no regrant.
- Non-power-of-two wrap: N=5, mode=1, req=5'b10001, ack each grant → sequence 0,4,0,4. Async reset asserted mid-grant → outputs clear before the next clk edge.
